// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add significand multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // Number of iterations needed to consume a full-width multiplier.
    function automatic int iters(input int w, input int radix_bits);
        return w / radix_bits;
    endfunction

endpackage

// File: rtl/shift_add_dp.sv
// Shift-add datapath: holds operands and the accumulator, adds one multiplier
// digit times the multiplicand per step, and aligns the product for early exit.
module shift_add_dp #(
    parameter int W          = 8,
    parameter int RADIX_BITS = 1,
    parameter int CW         = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              load,
    input  logic              step,
    input  logic [W-1:0]      a,
    input  logic [W-1:0]      b,
    input  logic [CW-1:0]     digits_done,
    output logic [2*W-1:0]    product,
    output logic              mplr_zero
);
    import mult_pkg::*;

    localparam int N  = iters(W, RADIX_BITS);
    localparam int AW = 2 * W + RADIX_BITS;

    logic [W-1:0]            b_reg;
    logic [W-1:0]            mplr;
    logic [AW-1:0]           acc;
    logic [W-1:0]            mplr_next;
    logic [W+RADIX_BITS-1:0] digit_prod;
    logic [W+RADIX_BITS:0]   hi_sum;
    logic [AW:0]             acc_wide;
    logic [AW-1:0]           acc_next;
    logic [31:0]             skip_digits;

    // Drop the digit positions that were never iterated so the result is a*b.
    function automatic logic [2*W-1:0] align_product(input logic [AW-1:0] v,
                                                     input logic [31:0]  skip);
        return (2*W)'(v >> (skip * RADIX_BITS));
    endfunction

    // Next-state arithmetic: digit multiple of b into the upper half, then shift right one digit.
    always_comb begin
        digit_prod  = {{W{1'b0}}, mplr[RADIX_BITS-1:0]} * {{RADIX_BITS{1'b0}}, b_reg};
        hi_sum      = {1'b0, acc[AW-1:W]} + {1'b0, digit_prod};
        acc_wide    = {hi_sum, acc[W-1:0]};
        acc_next    = AW'(acc_wide >> RADIX_BITS);
        mplr_next   = mplr >> RADIX_BITS;
        mplr_zero   = (mplr_next == '0);
        skip_digits = 32'(N) - 32'(digits_done);
        product     = align_product(acc_next, skip_digits);
    end

    // Operand capture on accept, one digit retired per CALC cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            b_reg <= '0;
            mplr  <= '0;
            acc   <= '0;
        end else if (load) begin
            b_reg <= b;
            mplr  <= a;
            acc   <= '0;
        end else if (step) begin
            mplr  <= mplr_next;
            acc   <= acc_next;
        end
    end

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential unsigned shift-add multiplier for FPM significand products with a
// start/ready/valid handshake, optional early exit and an iteration counter.
module seq_shift_add_mult #(
    parameter int W          = 8,
    parameter int RADIX_BITS = 1,
    parameter int EARLY_EXIT = 0
) (
    input  logic                                 clk_in,
    input  logic                                 rst_in,
    input  logic [W-1:0]                         a_in,
    input  logic [W-1:0]                         b_in,
    input  logic                                 start_in,
    output logic [2*W-1:0]                       p_out,
    output logic                                 valid_out,
    output logic                                 ready_out,
    output logic [$clog2(W/RADIX_BITS+1)-1:0]    iter_out
);
    import mult_pkg::*;

    localparam int N  = iters(W, RADIX_BITS);
    localparam int CW = $clog2(N + 1);

    if ((RADIX_BITS != 1 && RADIX_BITS != 2) || (W % RADIX_BITS != 0) || (W < 2)) begin : g_bad_params
        $error("seq_shift_add_mult: illegal W/RADIX_BITS combination");
    end

    mult_state_t       state;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_next;
    logic              accept;
    logic              step;
    logic              last;
    logic [2*W-1:0]    product;
    logic              mplr_zero;

    assign ready_out = (state == IDLE) || (state == DONE);
    assign accept    = start_in && ready_out;
    assign step      = (state == CALC);
    assign cnt_next  = cnt + CW'(1);
    assign last      = (cnt_next == CW'(N)) || ((EARLY_EXIT != 0) && mplr_zero);

    shift_add_dp #(
        .W          (W),
        .RADIX_BITS (RADIX_BITS),
        .CW         (CW)
    ) u_dp (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .load        (accept),
        .step        (step),
        .a           (a_in),
        .b           (b_in),
        .digits_done (cnt_next),
        .product     (product),
        .mplr_zero   (mplr_zero)
    );

    // Handshake FSM with registered product, valid pulse and iteration count.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= IDLE;
            cnt       <= '0;
            p_out     <= '0;
            valid_out <= 1'b0;
            iter_out  <= '0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= CALC;
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    cnt <= cnt_next;
                    if (last) begin
                        state     <= DONE;
                        p_out     <= product;
                        iter_out  <= cnt_next;
                        valid_out <= 1'b1;
                    end
                end
                DONE: begin
                    if (accept) begin
                        state <= CALC;
                        cnt   <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Bench for seq_shift_add_mult across four parameter sets, with a shared
// scoreboard fed at accept time and drained when valid_out pulses.
`timescale 1ns/1ps
module tb_seq_shift_add_mult;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] a_v [4];
    logic [15:0] b_v [4];
    logic [3:0]  start_v;
    logic [3:0]  valid_v;
    logic [3:0]  ready_v;
    logic [15:0] p0, p1, p2;
    logic [31:0] p3;
    logic [3:0]  it0;
    logic [2:0]  it1;
    logic [3:0]  it2, it3;
    logic [31:0] p_v [4];
    logic [7:0]  it_v [4];

    int passed = 0;
    int total  = 0;

    typedef struct {
        int          dut;
        logic [31:0] p;
        int          iters;
    } sb_t;
    sb_t sb[$];
    sb_t mon_e;

    typedef struct {
        int          dut;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
        int          lat;
    } vec_t;
    vec_t vecs [12];

    seq_shift_add_mult #(.W(8), .RADIX_BITS(1), .EARLY_EXIT(0)) u_d0 (
        .clk_in(clk), .rst_in(rst), .a_in(a_v[0][7:0]), .b_in(b_v[0][7:0]),
        .start_in(start_v[0]), .p_out(p0), .valid_out(valid_v[0]),
        .ready_out(ready_v[0]), .iter_out(it0));
    seq_shift_add_mult #(.W(8), .RADIX_BITS(2), .EARLY_EXIT(0)) u_d1 (
        .clk_in(clk), .rst_in(rst), .a_in(a_v[1][7:0]), .b_in(b_v[1][7:0]),
        .start_in(start_v[1]), .p_out(p1), .valid_out(valid_v[1]),
        .ready_out(ready_v[1]), .iter_out(it1));
    seq_shift_add_mult #(.W(8), .RADIX_BITS(1), .EARLY_EXIT(1)) u_d2 (
        .clk_in(clk), .rst_in(rst), .a_in(a_v[2][7:0]), .b_in(b_v[2][7:0]),
        .start_in(start_v[2]), .p_out(p2), .valid_out(valid_v[2]),
        .ready_out(ready_v[2]), .iter_out(it2));
    seq_shift_add_mult #(.W(16), .RADIX_BITS(2), .EARLY_EXIT(1)) u_d3 (
        .clk_in(clk), .rst_in(rst), .a_in(a_v[3]), .b_in(b_v[3]),
        .start_in(start_v[3]), .p_out(p3), .valid_out(valid_v[3]),
        .ready_out(ready_v[3]), .iter_out(it3));

    always_comb begin
        p_v[0]  = {16'h0, p0};
        p_v[1]  = {16'h0, p1};
        p_v[2]  = {16'h0, p2};
        p_v[3]  = p3;
        it_v[0] = {4'h0, it0};
        it_v[1] = {5'h0, it1};
        it_v[2] = {4'h0, it2};
        it_v[3] = {4'h0, it3};
    end

    function automatic int dut_w(input int i);
        return (i == 3) ? 16 : 8;
    endfunction

    function automatic int dut_r(input int i);
        return (i == 1 || i == 3) ? 2 : 1;
    endfunction

    function automatic int dut_ee(input int i);
        return (i >= 2) ? 1 : 0;
    endfunction

    // Reference iteration count: full digit count, or significant digits of a when exiting early.
    function automatic int model_iters(input int i, input logic [15:0] a);
        int n;
        logic [15:0] t;
        if (dut_ee(i) == 0) return dut_w(i) / dut_r(i);
        n = 0;
        t = a;
        while (t != 16'h0) begin
            t = t >> dut_r(i);
            n++;
        end
        if (n == 0) n = 1;
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual %h required %h", name, act, exp);
    endtask

    // Scoreboard drain: every valid pulse must match the oldest outstanding operation.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                if (valid_v[i]) begin
                    if (sb.size() == 0) begin
                        check($sformatf("unexpected_valid_dut%0d", i), 32'(valid_v[i]), 32'd0);
                    end else begin
                        mon_e = sb.pop_front();
                        check($sformatf("sb_dut%0d", i), 32'(i), 32'(mon_e.dut));
                        check($sformatf("product_dut%0d", i), p_v[i], mon_e.p);
                        check($sformatf("iter_out_dut%0d", i), 32'(it_v[i]), 32'(mon_e.iters));
                    end
                end
            end
        end
    end

    task automatic run_op(input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] p_exp, input int lat_exp, input string tag);
        int  waited;
        int  lat;
        sb_t e;
        @(negedge clk);
        waited = 0;
        while (!ready_v[i] && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!ready_v[i]) begin
            check({tag, "_ready_timeout"}, 32'(ready_v[i]), 32'd1);
            return;
        end
        a_v[i]     = a;
        b_v[i]     = b;
        start_v[i] = 1'b1;
        e.dut   = i;
        e.p     = p_exp;
        e.iters = lat_exp;
        sb.push_back(e);
        @(posedge clk);
        #1 start_v[i] = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!valid_v[i] && lat < 40);
        check({tag, "_latency"}, 32'(lat), 32'(lat_exp));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        sb_t         e;
        logic [15:0] ra, rb, mask;

        vecs[0]  = '{0, 16'h00FF, 16'h00FF, 32'h0000FE01, 8};
        vecs[1]  = '{1, 16'h00B7, 16'h005D, 32'h0000427B, 4};
        vecs[2]  = '{2, 16'h0003, 16'h0080, 32'h00000180, 2};
        vecs[3]  = '{2, 16'h0000, 16'h00AA, 32'h00000000, 1};
        vecs[4]  = '{3, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 8};
        vecs[5]  = '{0, 16'h0000, 16'h00AA, 32'h00000000, 8};
        vecs[6]  = '{1, 16'h00FF, 16'h0000, 32'h00000000, 4};
        vecs[7]  = '{2, 16'h0080, 16'h00FF, 32'h00007F80, 8};
        vecs[8]  = '{3, 16'h0001, 16'hFFFF, 32'h0000FFFF, 1};
        vecs[9]  = '{1, 16'h0003, 16'h00FF, 32'h000002FD, 4};
        vecs[10] = '{3, 16'h0100, 16'h1234, 32'h00123400, 5};
        vecs[11] = '{2, 16'h0005, 16'h0011, 32'h00000055, 3};

        rst     = 1'b1;
        start_v = 4'h0;
        for (int i = 0; i < 4; i++) begin
            a_v[i] = 16'h0;
            b_v[i] = 16'h0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset_p_dut%0d", i), p_v[i], 32'h0);
            check($sformatf("reset_valid_dut%0d", i), 32'(valid_v[i]), 32'd0);
            check($sformatf("reset_ready_dut%0d", i), 32'(ready_v[i]), 32'd1);
            check($sformatf("reset_iter_dut%0d", i), 32'(it_v[i]), 32'd0);
        end

        for (int k = 0; k < 12; k++)
            run_op(vecs[k].dut, vecs[k].a, vecs[k].b, vecs[k].p, vecs[k].lat, $sformatf("vec%0d", k));

        // Back-to-back with start held, inputs changed after accept, stray start mid-CALC.
        repeat (3) @(negedge clk);
        a_v[0] = 16'h0012;
        b_v[0] = 16'h0034;
        start_v[0] = 1'b1;
        e = '{0, 32'h000003A8, 8};
        sb.push_back(e);
        e = '{0, 32'h000000E1, 8};
        sb.push_back(e);
        @(posedge clk);
        #1 a_v[0] = 16'h000F;
        b_v[0] = 16'h000F;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!valid_v[0] && lat < 40);
        check("b2b_latency1", 32'(lat), 32'd8);
        check("b2b_ready_in_done", 32'(ready_v[0]), 32'd1);
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        check("b2b_valid_drop", 32'(valid_v[0]), 32'd0);
        check("b2b_p_hold", p_v[0], 32'h000003A8);
        check("b2b_busy", 32'(ready_v[0]), 32'd0);
        @(posedge clk);
        #1 start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        lat = 2;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!valid_v[0] && lat < 40);
        check("b2b_latency2", 32'(lat), 32'd8);
        repeat (12) @(posedge clk);
        #1 check("calc_start_ignored_idle", 32'(ready_v[0]), 32'd1);

        // Reset asserted on the third CALC edge abandons the operation.
        @(negedge clk);
        a_v[0] = 16'h0055;
        b_v[0] = 16'h0033;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrst_valid", 32'(valid_v[0]), 32'd0);
        check("midrst_p", p_v[0], 32'h0);
        check("midrst_ready", 32'(ready_v[0]), 32'd1);
        check("midrst_iter", 32'(it_v[0]), 32'd0);
        repeat (10) @(posedge clk);
        run_op(0, 16'h0080, 16'h0002, 32'h00000100, 8, "after_rst");

        // Random operands against the a*b reference, biased toward short multipliers.
        for (int i = 0; i < 4; i++) begin
            mask = (dut_w(i) == 16) ? 16'hFFFF : 16'h00FF;
            for (int n = 0; n < 150; n++) begin
                if ($urandom_range(0, 3) == 0) ra = 16'($urandom_range(0, 15));
                else ra = 16'($urandom) & mask;
                rb = 16'($urandom) & mask;
                run_op(i, ra, rb, 32'(ra) * 32'(rb), model_iters(i, ra), $sformatf("rnd_dut%0d", i));
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            end
        end

        repeat (20) @(posedge clk);
        #1 check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
